// File: rtl/garage_door_scheduler.sv
// garage_door_scheduler
//   Shares one motor supply between N_DOORS garage doors. Button presses are latched per door,
//   doors are served round-robin one at a time, and the travel direction is picked from the
//   limit switches. A closing door that breaks the beam is reversed. Each travel leg is guarded
//   by a watchdog, and doors that time out or report both limits get a sticky fault flag.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   req        per-door button pulse
//   up_max     per-door fully-open limit switch
//   dn_max     per-door fully-closed limit switch
//   obstruct   per-door beam-break (acted on only while closing)
//   fault_clr  pulse, clears every fault bit
//   up_m       per-door raise motor enable
//   dn_m       per-door lower motor enable
//   grant      one-hot door currently owned, zero when idle
//   busy       scheduler is not idle
//   fault      sticky per-door fault flags
module garage_door_scheduler #(
  parameter int unsigned N_DOORS = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 11
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_DOORS-1:0] req,
  input  logic [N_DOORS-1:0] up_max,
  input  logic [N_DOORS-1:0] dn_max,
  input  logic [N_DOORS-1:0] obstruct,
  input  logic               fault_clr,
  output logic [N_DOORS-1:0] up_m,
  output logic [N_DOORS-1:0] dn_m,
  output logic [N_DOORS-1:0] grant,
  output logic               busy,
  output logic [N_DOORS-1:0] fault
);

  localparam int unsigned IdxW = (N_DOORS > 1) ? $clog2(N_DOORS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StMoveUp,
    StMoveDn,
    StSettle,
    StSettleRev
  } state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      cur_q, cur_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     wd_q, wd_d;
  logic [N_DOORS-1:0]   pending_q, pending_d;
  logic [N_DOORS-1:0]   fault_q, fault_d;

  logic [N_DOORS-1:0]   fault_set;
  logic [N_DOORS-1:0]   pend_clr;
  logic                 sel_found;
  logic [IdxW-1:0]      sel_idx;
  logic [IdxW-1:0]      cand;
  logic                 wd_expired;

  assign wd_expired = (wd_q == CNT_W'(TIMEOUT - 1));

  // Round-robin pick: first pending door strictly after rr_ptr, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_DOORS; k++) begin
      cand = IdxW'((32'(rr_ptr_q) + k) % N_DOORS);
      if (!sel_found && pending_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    rr_ptr_d  = rr_ptr_q;
    wd_d      = wd_q;
    fault_set = '0;
    pend_clr  = '0;

    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          cur_d             = sel_idx;
          rr_ptr_d          = sel_idx;
          wd_d              = '0;
          pend_clr[sel_idx] = 1'b1;
          if (up_max[sel_idx] && dn_max[sel_idx]) begin
            // Both limits at once means a broken switch: refuse to move.
            fault_set[sel_idx] = 1'b1;
          end else if (dn_max[sel_idx]) begin
            state_d = StMoveUp;
          end else begin
            // Fully open or somewhere in between: close it.
            state_d = StMoveDn;
          end
        end
      end

      StMoveUp: begin
        wd_d = wd_q + CNT_W'(1);
        if (up_max[cur_q]) begin
          state_d = StSettle;
        end else if (wd_expired) begin
          fault_set[cur_q] = 1'b1;
          state_d          = StSettle;
        end
      end

      StMoveDn: begin
        wd_d = wd_q + CNT_W'(1);
        if (dn_max[cur_q]) begin
          state_d = StSettle;
        end else if (obstruct[cur_q]) begin
          state_d = StSettleRev;
        end else if (wd_expired) begin
          fault_set[cur_q] = 1'b1;
          state_d          = StSettle;
        end
      end

      StSettle: begin
        state_d = StIdle;
      end

      StSettleRev: begin
        // Fresh watchdog budget for the reopening leg.
        wd_d    = '0;
        state_d = StMoveUp;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // A newly set fault beats a simultaneous clear.
    fault_d   = (fault_q & ~{N_DOORS{fault_clr}}) | fault_set;
    pending_d = (pending_q | (req & ~fault_q & ~grant)) & ~pend_clr & ~fault_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cur_q     <= '0;
      rr_ptr_q  <= IdxW'(N_DOORS - 1);
      wd_q      <= '0;
      pending_q <= '0;
      fault_q   <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      rr_ptr_q  <= rr_ptr_d;
      wd_q      <= wd_d;
      pending_q <= pending_d;
      fault_q   <= fault_d;
    end
  end

  // Moore outputs, decoded from registered state so the async reset drops motors at once.
  always_comb begin
    up_m  = '0;
    dn_m  = '0;
    grant = '0;
    busy  = (state_q != StIdle);
    fault = fault_q;
    unique case (state_q)
      StMoveUp: begin
        up_m[cur_q]  = 1'b1;
        grant[cur_q] = 1'b1;
      end
      StMoveDn: begin
        dn_m[cur_q]  = 1'b1;
        grant[cur_q] = 1'b1;
      end
      StSettle, StSettleRev: begin
        grant[cur_q] = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_garage_door_scheduler.sv
// Bench for garage_door_scheduler: a door-level behavioural model (owner, motor direction,
// dead-cycle kind, on-cycle count, pending set) runs alongside the DUT and is compared on every
// falling edge, while directed scenarios add literal expectations.
module tb_garage_door_scheduler;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int CW = 5;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] req, up_max, dn_max, obstruct;
  logic         fault_clr;
  logic [N-1:0] up_m, dn_m, grant, fault;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  garage_door_scheduler #(
    .N_DOORS (N),
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .up_max    (up_max),
    .dn_max    (dn_max),
    .obstruct  (obstruct),
    .fault_clr (fault_clr),
    .up_m      (up_m),
    .dn_m      (dn_m),
    .grant     (grant),
    .busy      (busy),
    .fault     (fault)
  );

  // ---------------- behavioural model ----------------
  // m_owner: door holding the supply (-1 none); m_motor: 0 off, 1 raising, 2 lowering;
  // m_dead: 0 none, 1 dead cycle then release, 2 dead cycle then reopen.
  int           m_owner = -1;
  int           m_motor = 0;
  int           m_dead  = 0;
  int           m_on    = 0;
  int           m_last  = N - 1;
  bit [N-1:0]   m_pend  = '0;
  bit [N-1:0]   m_fault = '0;

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] one;
    one = 1;
    return (i >= 0) ? (one << i) : '0;
  endfunction

  function automatic logic [N-1:0] exp_up();
    return (m_motor == 1) ? onehot(m_owner) : '0;
  endfunction

  function automatic logic [N-1:0] exp_dn();
    return (m_motor == 2) ? onehot(m_owner) : '0;
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    bit [N-1:0] nf, acc;
    int         pick;
    if (!reset_n) begin
      m_owner = -1; m_motor = 0; m_dead = 0; m_on = 0; m_last = N - 1;
      m_pend  = '0; m_fault = '0;
    end else begin
      nf   = '0;
      pick = -1;
      acc  = req & ~m_fault & ~onehot(m_owner);
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++)
          if (pick < 0 && m_pend[(m_last + k) % N]) pick = (m_last + k) % N;
        if (pick >= 0) begin
          m_last = pick;
          if (up_max[pick] && dn_max[pick]) nf[pick] = 1'b1;
          else begin
            m_owner = pick;
            m_on    = 0;
            m_motor = dn_max[pick] ? 1 : 2;
          end
        end
      end else if (m_dead == 2) begin
        m_dead = 0; m_motor = 1; m_on = 0;
      end else if (m_dead == 1) begin
        m_dead = 0; m_owner = -1;
      end else begin
        m_on++;
        if (m_motor == 1) begin
          if (up_max[m_owner]) begin m_motor = 0; m_dead = 1; end
          else if (m_on == TO) begin nf[m_owner] = 1'b1; m_motor = 0; m_dead = 1; end
        end else begin
          if (dn_max[m_owner]) begin m_motor = 0; m_dead = 1; end
          else if (obstruct[m_owner]) begin m_motor = 0; m_dead = 2; end
          else if (m_on == TO) begin nf[m_owner] = 1'b1; m_motor = 0; m_dead = 1; end
        end
      end
      m_pend = m_pend | acc;
      if (pick >= 0) m_pend[pick] = 1'b0;
      m_fault = (fault_clr ? '0 : m_fault) | nf;
      m_pend  = m_pend & ~m_fault;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model up_m",  32'(up_m),  32'(exp_up()));
    chk("model dn_m",  32'(dn_m),  32'(exp_dn()));
    chk("model grant", 32'(grant), 32'(onehot(m_owner)));
    chk("model busy",  32'(busy),  32'(m_owner >= 0));
    chk("model fault", 32'(fault), 32'(m_fault));
    chk("one motor",   32'($countones(up_m | dn_m) <= 1), 32'(1));
    chk("no up&dn",    32'(up_m & dn_m), 32'(0));
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req(logic [N-1:0] v);
    req = v;
    cyc(1);
    req = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
  endtask

  int cnt;

  initial begin
    reset_n   = 1'b0;
    req       = '0;
    up_max    = '0;
    dn_max    = '0;
    obstruct  = '0;
    fault_clr = 1'b0;
    cyc(3);
    chk("reset up_m",  32'(up_m),  0);
    chk("reset dn_m",  32'(dn_m),  0);
    chk("reset grant", 32'(grant), 0);
    chk("reset busy",  32'(busy),  0);
    chk("reset fault", 32'(fault), 0);
    reset_n = 1'b1;
    cyc(1);

    // 1: door 1 closed, opens, stops on up_max.
    dn_max = 4'b1111;
    pulse_req(4'b0010);
    chk("t1 not yet moving", 32'(up_m), 0);
    cyc(1);
    chk("t1 up_m start", 32'(up_m), 32'h2);
    chk("t1 grant", 32'(grant), 32'h2);
    dn_max[1] = 1'b0;
    cyc(8);
    up_max[1] = 1'b1;
    cyc(1);
    chk("t1 motor off", 32'(up_m), 0);
    chk("t1 busy in settle", 32'(busy), 1);
    cyc(1);
    chk("t1 idle", 32'(busy), 0);

    // 2: simultaneous requests from reset, door 0 first, then door 2.
    do_reset();
    up_max = '0;
    dn_max = 4'b1111;
    pulse_req(4'b0101);
    cyc(1);
    chk("t2 door0 first", 32'(up_m), 32'h1);
    dn_max[0] = 1'b0;
    cyc(5);
    up_max[0] = 1'b1;
    cyc(1);
    chk("t2 off after limit", 32'(up_m), 0);
    cyc(1);
    chk("t2 idle gap", 32'(busy), 0);
    cyc(1);
    chk("t2 door2 starts", 32'(up_m), 32'h4);
    dn_max[2] = 1'b0;
    cyc(4);
    up_max[2] = 1'b1;
    cyc(3);

    // 3: round robin after door 0 was served.
    do_reset();
    pulse_req(4'b0001);
    cyc(1);
    chk("t3 door0 closes", 32'(dn_m), 32'h1);
    up_max[0] = 1'b0;
    cyc(3);
    dn_max[0] = 1'b1;
    cyc(2);
    pulse_req(4'b0011);
    cyc(1);
    chk("t3 door1 before door0", 32'(grant), 32'h2);
    dn_max[1] = 1'b0;
    cyc(3);
    up_max[1] = 1'b1;
    cyc(3);
    chk("t3 door0 next", 32'(up_m), 32'h1);
    dn_max[0] = 1'b0;
    cyc(3);
    up_max[0] = 1'b1;
    cyc(2);

    // 4: obstruction reversal on door 3, then limit beating obstruct.
    dn_max[3] = 1'b0;
    up_max[3] = 1'b1;
    pulse_req(4'b1000);
    cyc(1);
    chk("t4 closing", 32'(dn_m), 32'h8);
    up_max[3] = 1'b0;
    cyc(3);
    obstruct[3] = 1'b1;
    cyc(1);
    obstruct = '0;
    chk("t4 dead dn", 32'(dn_m), 0);
    chk("t4 dead up", 32'(up_m), 0);
    chk("t4 grant held", 32'(grant), 32'h8);
    cyc(1);
    chk("t4 reopening", 32'(up_m), 32'h8);
    cyc(4);
    up_max[3] = 1'b1;
    cyc(1);
    chk("t4 stop", 32'(up_m), 0);
    cyc(1);
    chk("t4 idle", 32'(busy), 0);
    pulse_req(4'b1000);
    cyc(1);
    up_max[3] = 1'b0;
    cyc(2);
    dn_max[3]   = 1'b1;
    obstruct[3] = 1'b1;
    cyc(1);
    obstruct = '0;
    chk("t4 limit stop", 32'(dn_m), 0);
    cyc(1);
    chk("t4 limit wins, idle", 32'(busy), 0);
    cyc(1);
    chk("t4 no reversal", 32'(up_m), 0);

    // 5: watchdog on door 2 stuck mid-travel.
    up_max[2] = 1'b0;
    dn_max[2] = 1'b0;
    pulse_req(4'b0100);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dn_m[2]) cnt++;
    end
    chk("t5 on cycles", 32'(cnt), 16);
    chk("t5 fault", 32'(fault), 32'h4);
    pulse_req(4'b0100);
    cyc(3);
    chk("t5 faulted req ignored", 32'(busy), 0);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    chk("t5 fault cleared", 32'(fault), 0);
    pulse_req(4'b0100);
    cyc(1);
    chk("t5 served after clear", 32'(dn_m), 32'h4);
    dn_max[2] = 1'b1;
    cyc(3);

    // Double limit, and a set beating a simultaneous clear.
    dn_max[1] = 1'b1;
    pulse_req(4'b0010);
    cyc(1);
    chk("dbl fault", 32'(fault), 32'h2);
    chk("dbl no motor", 32'(up_m | dn_m), 0);
    dn_max[0] = 1'b1;
    pulse_req(4'b0001);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    chk("set beats clear", 32'(fault), 32'h1);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    dn_max[1] = 1'b0;
    cyc(1);

    // 6: async reset in the middle of a move.
    up_max[0] = 1'b0;
    dn_max[0] = 1'b1;
    pulse_req(4'b0001);
    cyc(1);
    chk("t6 moving", 32'(up_m), 32'h1);
    dn_max[0] = 1'b0;
    pulse_req(4'b0010);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6 async up_m", 32'(up_m), 0);
    chk("t6 async dn_m", 32'(dn_m), 0);
    chk("t6 async busy", 32'(busy), 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(6);
    chk("t6 no stale request", 32'(up_m | dn_m), 0);
    chk("t6 still idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
